// File: rtl/dma_burst_writer.sv
// Buffers input words in a fall-through FIFO and drains them as an address-incrementing burst into a buffer write port.
// Latency: pop in cycle N gives buf_wen in N+1. Backpressure: buf_ready gates pops; pushes into a full FIFO are dropped.
module dma_burst_writer #(
  parameter int DATA_WIDTH     = 32,
  parameter int FIFO_DEPTH     = 16,
  parameter int BUF_ADDR_WIDTH = 12
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DATA_WIDTH-1:0]         in_wdata,
  input  logic                          in_wen,
  output logic                          in_full,
  input  logic [BUF_ADDR_WIDTH-1:0]     cfg_base,
  input  logic [BUF_ADDR_WIDTH:0]       cfg_len,
  input  logic                          cfg_start,
  input  logic                          cfg_abort,
  input  logic                          buf_ready,
  output logic                          buf_wen,
  output logic [BUF_ADDR_WIDTH-1:0]     buf_addr,
  output logic [DATA_WIDTH-1:0]         buf_wdata,
  output logic                          busy,
  output logic                          done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [31:0]                   words_written,
  output logic [15:0]                   drop_count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0]        FULL_CNT = CNT_W'(FIFO_DEPTH);
  localparam logic [BUF_ADDR_WIDTH:0] LAST_WORD = (BUF_ADDR_WIDTH+1)'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [DATA_WIDTH-1:0]     mem [FIFO_DEPTH];
  logic [PTR_W-1:0]          wr_ptr, rd_ptr;
  logic [CNT_W-1:0]          count;
  logic [BUF_ADDR_WIDTH-1:0] addr_ptr;
  logic [BUF_ADDR_WIDTH:0]   remaining;

  logic push, pop, fifo_wr, start_ok;

  assign fifo_level = count;
  assign in_full    = (count == FULL_CNT);
  assign busy       = (state != IDLE);
  assign done       = (state == DONE);

  assign push     = in_wen && !in_full;
  // Abort discards a same-cycle push outright.
  assign fifo_wr  = push && !cfg_abort;
  assign pop      = (state == RUN) && (count != '0) && buf_ready;
  assign start_ok = (state == IDLE) && cfg_start && !cfg_abort && (cfg_len != '0);

  always_ff @(posedge clk) begin
    if (fifo_wr) begin
      mem[wr_ptr] <= in_wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (cfg_abort) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (cfg_start) begin
          state_nxt = (cfg_len != '0) ? RUN : DONE;
        end
      end
      RUN: begin
        if (pop && (remaining == LAST_WORD)) begin
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (cfg_abort) begin
      state_nxt = IDLE;
    end
  end

  // A pop in the abort cycle still produces its write on the next cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_ptr      <= '0;
      remaining     <= '0;
      buf_wen       <= 1'b0;
      buf_addr      <= '0;
      buf_wdata     <= '0;
      words_written <= '0;
      drop_count    <= '0;
    end else begin
      buf_wen <= pop;
      if (pop) begin
        buf_addr      <= addr_ptr;
        buf_wdata     <= mem[rd_ptr];
        words_written <= words_written + 32'd1;
      end
      if (start_ok) begin
        addr_ptr  <= cfg_base;
        remaining <= cfg_len;
      end else if (pop) begin
        addr_ptr  <= addr_ptr + 1'b1;
        remaining <= remaining - 1'b1;
      end
      if (in_wen && in_full && !cfg_abort && (drop_count != 16'hFFFF)) begin
        drop_count <= drop_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_dma_burst_writer.sv
// Directed bench for dma_burst_writer: burst ordering, overflow, backpressure/wrap, zero length, abort, async reset.
module tb_dma_burst_writer;

  logic        clk;
  logic        rst;
  logic [31:0] in_wdata;
  logic        in_wen;
  logic        in_full;
  logic [11:0] cfg_base;
  logic [12:0] cfg_len;
  logic        cfg_start;
  logic        cfg_abort;
  logic        buf_ready;
  logic        buf_wen;
  logic [11:0] buf_addr;
  logic [31:0] buf_wdata;
  logic        busy;
  logic        done;
  logic [4:0]  fifo_level;
  logic [31:0] words_written;
  logic [15:0] drop_count;

  int checks;
  int errors;

  dma_burst_writer #(.DATA_WIDTH(32), .FIFO_DEPTH(16), .BUF_ADDR_WIDTH(12)) dut (
    .clk(clk), .rst(rst), .in_wdata(in_wdata), .in_wen(in_wen), .in_full(in_full),
    .cfg_base(cfg_base), .cfg_len(cfg_len), .cfg_start(cfg_start), .cfg_abort(cfg_abort),
    .buf_ready(buf_ready), .buf_wen(buf_wen), .buf_addr(buf_addr), .buf_wdata(buf_wdata),
    .busy(busy), .done(done), .fifo_level(fifo_level), .words_written(words_written),
    .drop_count(drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Write monitor, sampled on the falling edge
  logic [11:0] wr_addr [$];
  logic [31:0] wr_data [$];
  logic        wr_done [$];
  int          done_cnt;
  int          viol;
  logic        prev_rdy;

  initial prev_rdy = 1'b1;
  always @(negedge clk) begin
    if (buf_wen === 1'b1) begin
      wr_addr.push_back(buf_addr);
      wr_data.push_back(buf_wdata);
      wr_done.push_back(done);
    end
    if (done === 1'b1) done_cnt++;
    if (buf_wen === 1'b1 && !prev_rdy) viol++;
    prev_rdy = buf_ready;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    wr_addr.delete();
    wr_data.delete();
    wr_done.delete();
    done_cnt = 0;
    viol = 0;
  endtask

  task automatic push_words(input logic [31:0] first, input int n);
    for (int i = 0; i < n; i++) begin
      in_wen = 1'b1;
      in_wdata = first + 32'(i);
      tick();
    end
    in_wen = 1'b0;
  endtask

  task automatic start_burst(input logic [11:0] b, input logic [12:0] l);
    cfg_base = b;
    cfg_len = l;
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 200) begin
      tick();
      n++;
    end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL wait_idle: busy got %b expected 0 after 200 cycles", busy); end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (buf_wen !== 1'b0) begin errors++; $display("FAIL reset_buf_wen: got %b expected 0", buf_wen); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
    checks++; if (in_full !== 1'b0) begin errors++; $display("FAIL reset_in_full: got %b expected 0", in_full); end
    checks++; if (fifo_level !== 5'd0) begin errors++; $display("FAIL reset_level: got %0d expected 0", fifo_level); end
    checks++; if (words_written !== 32'd0) begin errors++; $display("FAIL reset_words: got %0d expected 0", words_written); end
    checks++; if (drop_count !== 16'd0) begin errors++; $display("FAIL reset_drop: got %0d expected 0", drop_count); end
    checks++; if (buf_addr !== 12'h0 || buf_wdata !== 32'h0) begin errors++; $display("FAIL reset_bus: got addr %h data %h expected 0 0", buf_addr, buf_wdata); end
    rst = 1'b0;
    buf_ready = 1'b1;
    tick();
  endtask

  task automatic test_prefill_burst();
    clear_mon();
    push_words(32'hA0, 4);
    checks++; if (fifo_level !== 5'd4) begin errors++; $display("FAIL prefill_level: got %0d expected 4", fifo_level); end
    start_burst(12'h010, 13'd4);
    checks++; if (busy !== 1'b1 || buf_wen !== 1'b0) begin errors++; $display("FAIL start_busy: got busy %b wen %b expected 1 0", busy, buf_wen); end
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (buf_wen !== 1'b1 || buf_addr !== 12'h010 + 12'(i) || buf_wdata !== 32'hA0 + 32'(i) || done !== (i == 3)) begin
        errors++;
        $display("FAIL burst_beat%0d: got wen %b addr %h data %h done %b expected 1 %h %h %b",
                 i, buf_wen, buf_addr, buf_wdata, done, 12'h010 + 12'(i), 32'hA0 + 32'(i), (i == 3));
      end
    end
    tick();
    checks++; if (busy !== 1'b0 || buf_wen !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL burst_end: got busy %b wen %b done %b expected 0 0 0", busy, buf_wen, done); end
    checks++; if (words_written !== 32'd4) begin errors++; $display("FAIL burst_words: got %0d expected 4", words_written); end
  endtask

  task automatic test_overflow();
    clear_mon();
    push_words(32'hB00, 16);
    checks++; if (in_full !== 1'b1 || fifo_level !== 5'd16) begin errors++; $display("FAIL ovf_full: got full %b level %0d expected 1 16", in_full, fifo_level); end
    checks++; if (drop_count !== 16'd0) begin errors++; $display("FAIL ovf_drop0: got %0d expected 0", drop_count); end
    push_words(32'hB10, 2);
    checks++; if (drop_count !== 16'd2 || fifo_level !== 5'd16) begin errors++; $display("FAIL ovf_drop: got drop %0d level %0d expected 2 16", drop_count, fifo_level); end
    start_burst(12'h100, 13'd16);
    wait_idle();
    checks++; if (wr_addr.size() != 16) begin errors++; $display("FAIL ovf_count: got %0d writes expected 16", wr_addr.size()); end
    for (int i = 0; i < 16 && i < wr_addr.size(); i++) begin
      checks++;
      if (wr_addr[i] !== 12'h100 + 12'(i) || wr_data[i] !== 32'hB00 + 32'(i)) begin
        errors++; $display("FAIL ovf_write%0d: got %h/%h expected %h/%h", i, wr_addr[i], wr_data[i], 12'h100 + 12'(i), 32'hB00 + 32'(i));
      end
    end
    checks++; if (fifo_level !== 5'd0 || done_cnt != 1) begin errors++; $display("FAIL ovf_after: got level %0d dones %0d expected 0 1", fifo_level, done_cnt); end
    checks++; if (words_written !== 32'd20) begin errors++; $display("FAIL ovf_words: got %0d expected 20", words_written); end
  endtask

  task automatic test_backpressure_wrap();
    logic [11:0] exp_a [4];
    exp_a[0] = 12'hFFE; exp_a[1] = 12'hFFF; exp_a[2] = 12'h000; exp_a[3] = 12'h001;
    clear_mon();
    push_words(32'hC0, 4);
    start_burst(12'hFFE, 13'd4);
    for (int k = 0; k < 60 && busy; k++) begin
      buf_ready = ~buf_ready;
      tick();
    end
    buf_ready = 1'b1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bp_timeout: busy got %b expected 0", busy); end
    checks++; if (viol != 0) begin errors++; $display("FAIL bp_ready: got %0d writes after ready=0 expected 0", viol); end
    checks++; if (wr_addr.size() != 4 || done_cnt != 1) begin errors++; $display("FAIL bp_count: got %0d writes %0d dones expected 4 1", wr_addr.size(), done_cnt); end
    for (int i = 0; i < 4 && i < wr_addr.size(); i++) begin
      checks++;
      if (wr_addr[i] !== exp_a[i] || wr_data[i] !== 32'hC0 + 32'(i)) begin
        errors++; $display("FAIL bp_write%0d: got %h/%h expected %h/%h", i, wr_addr[i], wr_data[i], exp_a[i], 32'hC0 + 32'(i));
      end
    end
    checks++; if (wr_done.size() == 4 && wr_done[3] !== 1'b1) begin errors++; $display("FAIL bp_done_last: got %b expected 1", wr_done[3]); end
  endtask

  task automatic test_zero_len_ignored_start();
    clear_mon();
    start_burst(12'h200, 13'd0);
    checks++; if (done !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL zero_done: got done %b busy %b expected 1 1", done, busy); end
    tick();
    checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL zero_end: got done %b busy %b expected 0 0", done, busy); end
    checks++; if (wr_addr.size() != 0 || words_written !== 32'd24) begin errors++; $display("FAIL zero_writes: got %0d writes total %0d expected 0 24", wr_addr.size(), words_written); end
    clear_mon();
    push_words(32'hD0, 10);
    start_burst(12'h300, 13'd8);
    tick();
    tick();
    start_burst(12'h400, 13'd8);
    wait_idle();
    checks++; if (wr_addr.size() != 8 || done_cnt != 1) begin errors++; $display("FAIL ign_count: got %0d writes %0d dones expected 8 1", wr_addr.size(), done_cnt); end
    for (int i = 0; i < 8 && i < wr_addr.size(); i++) begin
      checks++;
      if (wr_addr[i] !== 12'h300 + 12'(i) || wr_data[i] !== 32'hD0 + 32'(i)) begin
        errors++; $display("FAIL ign_write%0d: got %h/%h expected %h/%h", i, wr_addr[i], wr_data[i], 12'h300 + 12'(i), 32'hD0 + 32'(i));
      end
    end
    checks++; if (fifo_level !== 5'd2) begin errors++; $display("FAIL excess_level: got %0d expected 2", fifo_level); end
    clear_mon();
    start_burst(12'h500, 13'd2);
    wait_idle();
    checks++;
    if (wr_addr.size() != 2 || wr_addr[0] !== 12'h500 || wr_data[0] !== 32'hD8 || wr_addr[1] !== 12'h501 || wr_data[1] !== 32'hD9) begin
      errors++; $display("FAIL excess_data: got %0d writes expected D8@500 D9@501", wr_addr.size());
    end
    checks++; if (words_written !== 32'd34) begin errors++; $display("FAIL excess_words: got %0d expected 34", words_written); end
  endtask

  task automatic test_abort();
    clear_mon();
    push_words(32'hE0, 3);
    start_burst(12'h600, 13'd8);
    repeat (6) tick();
    checks++; if (wr_addr.size() != 3 || busy !== 1'b1) begin errors++; $display("FAIL abort_pre: got %0d writes busy %b expected 3 1", wr_addr.size(), busy); end
    cfg_abort = 1'b1;
    in_wen = 1'b1;
    in_wdata = 32'hEE;
    tick();
    cfg_abort = 1'b0;
    in_wen = 1'b0;
    checks++; if (fifo_level !== 5'd0 || busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL abort_state: got level %0d busy %b done %b expected 0 0 0", fifo_level, busy, done); end
    checks++; if (drop_count !== 16'd2) begin errors++; $display("FAIL abort_drop: got %0d expected 2", drop_count); end
    repeat (3) tick();
    checks++; if (done_cnt != 0 || wr_addr.size() != 3) begin errors++; $display("FAIL abort_after: got %0d dones %0d writes expected 0 3", done_cnt, wr_addr.size()); end
    checks++; if (words_written !== 32'd37) begin errors++; $display("FAIL abort_words: got %0d expected 37", words_written); end
  endtask

  task automatic test_reset_mid();
    clear_mon();
    push_words(32'hF0, 6);
    start_burst(12'h700, 13'd6);
    tick();
    tick();
    #2 rst = 1'b1;
    #1;
    checks++; if (buf_wen !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL arst_ctrl: got wen %b busy %b done %b expected 0 0 0", buf_wen, busy, done); end
    checks++; if (fifo_level !== 5'd0 || words_written !== 32'd0 || drop_count !== 16'd0) begin errors++; $display("FAIL arst_counts: got level %0d words %0d drop %0d expected 0 0 0", fifo_level, words_written, drop_count); end
    checks++; if (buf_addr !== 12'h0 || buf_wdata !== 32'h0) begin errors++; $display("FAIL arst_bus: got %h/%h expected 0/0", buf_addr, buf_wdata); end
    @(posedge clk);
    #1 rst = 1'b0;
    tick();
    clear_mon();
    push_words(32'h11, 2);
    start_burst(12'h020, 13'd2);
    wait_idle();
    checks++;
    if (wr_addr.size() != 2 || wr_addr[0] !== 12'h020 || wr_data[0] !== 32'h11 || wr_addr[1] !== 12'h021 || wr_data[1] !== 32'h12) begin
      errors++; $display("FAIL post_rst_burst: got %0d writes expected 11@020 12@021", wr_addr.size());
    end
    checks++; if (done_cnt != 1 || words_written !== 32'd2) begin errors++; $display("FAIL post_rst_done: got %0d dones words %0d expected 1 2", done_cnt, words_written); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b0;
    in_wdata = '0;
    in_wen = 1'b0;
    cfg_base = '0;
    cfg_len = '0;
    cfg_start = 1'b0;
    cfg_abort = 1'b0;
    buf_ready = 1'b0;
    done_cnt = 0;
    viol = 0;
    #2;
    test_reset();
    test_prefill_burst();
    test_overflow();
    test_backpressure_wrap();
    test_zero_len_ignored_start();
    test_abort();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
